bus_burst_ram_slave: RTL and testbench

Memory-mapped on-chip RAM slave on the shared burst bus. It is the far end of the DMA controller's bus transactions: it answers burst reads with `burst_size+1` data beats and absorbs burst writes with byte enables. It decodes its own address window, inserts configurable busy/wait cycles to exercise master flow control, and signals protocol or range errors on the bus.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_ram_byte_en.sv | 27 ++
 rtl/bus_burst_ram_slave.sv | 178 +++++++++++++++++
 tb/tb_bus_burst_ram_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared burst-bus slave types and address decode helper
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_READ_WAIT   = 3'd1,
        ST_READ_BURST  = 3'd2,
        ST_WRITE_BURST = 3'd3,
        ST_ERROR       = 3'd4
    } state_t;

    typedef logic [8:0] beat_cnt_t;

    // True when addr falls in the naturally aligned window of 2^win_bits bytes at base.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          win_bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << win_bits;
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/bus_ram_byte_en.sv
// rtl/bus_ram_byte_en.sv - single-port 32-bit RAM, byte write enables, 1-cycle read
module bus_ram_byte_en #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write_en,
    input  logic [3:0]            byte_en,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data
);

    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] read_data_q;

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (write_en && byte_en[i]) begin
                mem_q[addr][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
        read_data_q <= mem_q[addr];
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/bus_burst_ram_slave.sv
// rtl/bus_burst_ram_slave.sv - burst-bus RAM slave with window decode, wait/busy insertion and errors
module bus_burst_ram_slave
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS      = 32'h4000_0000,
    parameter int          ADDR_WIDTH        = 10,
    parameter int          READ_LATENCY      = 2,
    parameter int          WRITE_BUSY_PERIOD = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] busIn_address_data,
    input  logic [7:0]  busIn_burst_size,
    input  logic        busIn_read_n_write,
    input  logic        busIn_begin_transaction,
    input  logic        busIn_end_transaction,
    input  logic        busIn_data_valid,
    input  logic [3:0]  busIn_byte_enable,
    input  logic        busIn_error,
    output logic [31:0] busOut_address_data,
    output logic        busOut_data_valid,
    output logic        busOut_end_transaction,
    output logic        busOut_busy,
    output logic        busOut_error
);

    localparam logic [2:0]            WAIT_INIT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;
    localparam logic [7:0]            BUSY_N    = 8'(WRITE_BUSY_PERIOD);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH+8:0] MAX_WORD  = (ADDR_WIDTH+9)'((1 << ADDR_WIDTH) - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    beat_cnt_t               beats_q, beats_d;
    logic [3:0]              be_q, be_d;
    logic [2:0]              wait_q, wait_d;
    logic [7:0]              busy_cnt_q, busy_cnt_d;

    logic [ADDR_WIDTH-1:0]   in_word;
    logic [ADDR_WIDTH+8:0]   range_sum;
    logic                    selected, start, begin_err;
    logic                    busy, accept, overrun, ram_we;
    logic                    read_beat;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [31:0]             ram_rdata;

    always_comb begin
        in_word   = busIn_address_data[ADDR_WIDTH+1:2];
        range_sum = {9'd0, in_word} + {{(ADDR_WIDTH+1){1'b0}}, busIn_burst_size};
        selected  = addr_hit(busIn_address_data, BASE_ADDRESS, ADDR_WIDTH + 2);
        start     = (state_q == ST_IDLE) && busIn_begin_transaction && selected;
        begin_err = (busIn_address_data[1:0] != 2'b00) || (range_sum > MAX_WORD) ||
                    (!busIn_read_n_write && (busIn_byte_enable == 4'b0000));
        busy      = (state_q == ST_WRITE_BURST) && (BUSY_N != 8'd0) && (busy_cnt_q == BUSY_N);
        accept    = (state_q == ST_WRITE_BURST) && busIn_data_valid && !busy;
        overrun   = accept && (beats_q == 9'd0);
        ram_we    = accept && !overrun && !busIn_error;
        read_beat = (state_q == ST_READ_BURST) && (beats_q != 9'd0);
    end

    // Reads run one word ahead of the beat on the bus so beats stay back-to-back.
    always_comb begin
        case (state_q)
            ST_IDLE:       ram_addr = in_word;
            ST_READ_BURST: ram_addr = addr_q + ADDR_ONE;
            default:       ram_addr = addr_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (begin_err)               state_d = ST_ERROR;
                    else if (!busIn_read_n_write) state_d = ST_WRITE_BURST;
                    else if (READ_LATENCY > 1)   state_d = ST_READ_WAIT;
                    else                         state_d = ST_READ_BURST;
                end
            end
            ST_READ_WAIT: begin
                if (busIn_error || busIn_end_transaction) state_d = ST_IDLE;
                else if (wait_q == 3'd0)                  state_d = ST_READ_BURST;
            end
            ST_READ_BURST: begin
                if (busIn_error || busIn_end_transaction || (beats_q == 9'd0)) state_d = ST_IDLE;
            end
            ST_WRITE_BURST: begin
                if (busIn_error)                state_d = ST_IDLE;
                else if (overrun)               state_d = ST_ERROR;
                else if (busIn_end_transaction) state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            beats_q    <= '0;
            be_q       <= '0;
            wait_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            be_q       <= be_d;
            wait_q     <= wait_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        addr_d     = addr_q;
        beats_d    = beats_q;
        be_d       = be_q;
        wait_d     = wait_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = in_word;
                    beats_d    = {1'b0, busIn_burst_size} + 9'd1;
                    be_d       = busIn_byte_enable;
                    wait_d     = WAIT_INIT;
                    busy_cnt_d = 8'd1;
                end
            end
            ST_READ_WAIT: begin
                if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
            end
            ST_READ_BURST: begin
                if (read_beat) begin
                    beats_d = beats_q - 9'd1;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            ST_WRITE_BURST: begin
                busy_cnt_d = (busy_cnt_q == BUSY_N) ? 8'd1 : busy_cnt_q + 8'd1;
                if (ram_we) begin
                    beats_d = beats_q - 9'd1;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            default: ;
        endcase
    end

    // Outputs decode from the asynchronously reset state, so they fall with reset.
    always_comb begin
        busOut_data_valid      = read_beat;
        busOut_address_data    = read_beat ? ram_rdata : 32'd0;
        busOut_end_transaction = (state_q == ST_READ_BURST) && (beats_q == 9'd0);
        busOut_busy            = busy;
        busOut_error           = (state_q == ST_ERROR);
    end

    bus_ram_byte_en #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock      (clock),
        .addr       (ram_addr),
        .write_en   (ram_we),
        .byte_en    (be_q),
        .write_data (busIn_address_data),
        .read_data  (ram_rdata)
    );

endmodule

// File: tb/tb_bus_burst_ram_slave.sv
// tb/tb_bus_burst_ram_slave.sv - directed self-checking bench for bus_burst_ram_slave
module tb_bus_burst_ram_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          NLOG = 24;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_ad;
    logic [7:0]  in_bs;
    logic        in_rnw, in_begin, in_end, in_dv, in_err;
    logic [3:0]  in_be;
    logic [31:0] out_ad;
    logic        out_dv, out_end, out_busy, out_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] ad_log  [NLOG];
    logic        dv_log  [NLOG];
    logic        end_log [NLOG];
    logic        err_log [NLOG];
    logic [31:0] wdat    [8];
    logic [15:0] busy_mask;
    logic        err_seen;
    logic        acc;

    always #5 clock = ~clock;

    bus_burst_ram_slave #(
        .BASE_ADDRESS      (BASE),
        .ADDR_WIDTH        (10),
        .READ_LATENCY      (2),
        .WRITE_BUSY_PERIOD (3)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .busIn_address_data      (in_ad),
        .busIn_burst_size        (in_bs),
        .busIn_read_n_write      (in_rnw),
        .busIn_begin_transaction (in_begin),
        .busIn_end_transaction   (in_end),
        .busIn_data_valid        (in_dv),
        .busIn_byte_enable       (in_be),
        .busIn_error             (in_err),
        .busOut_address_data     (out_ad),
        .busOut_data_valid       (out_dv),
        .busOut_end_transaction  (out_end),
        .busOut_busy             (out_busy),
        .busOut_error            (out_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Logs outputs for cycles T+1 .. T+NLOG-1 after the begin edge T.
    task automatic run_read(input logic [31:0] addr, input logic [7:0] bs, input int err_cyc);
        in_ad = addr; in_bs = bs; in_rnw = 1'b1; in_begin = 1'b1;
        @(posedge clock); #1;
        in_begin = 1'b0; in_ad = '0;
        for (int c = 1; c < NLOG; c++) begin
            in_err = (c == err_cyc);
            @(negedge clock);
            ad_log[c] = out_ad; dv_log[c] = out_dv; end_log[c] = out_end; err_log[c] = out_err;
            @(posedge clock); #1;
        end
        in_err = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] bs,
                             input logic [3:0] be, input int n);
        int   cyc;
        logic b;
        busy_mask = '0; err_seen = 1'b0; cyc = 1; b = 1'b0;
        in_ad = addr; in_bs = bs; in_rnw = 1'b0; in_be = be; in_begin = 1'b1;
        @(posedge clock); #1;
        in_begin = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_ad = wdat[i]; in_dv = 1'b1;
            for (int t = 0; t < 8; t++) begin
                @(negedge clock);
                b = out_busy;
                if (b) busy_mask[cyc] = 1'b1;
                if (out_err) err_seen = 1'b1;
                @(posedge clock); #1;
                cyc++;
                if (!b) break;
            end
            check_eq("write_accept", b, 1'b0);
        end
        in_dv = 1'b0; in_ad = '0; in_end = 1'b1;
        @(negedge clock);
        if (out_err) err_seen = 1'b1;
        @(posedge clock); #1;
        in_end = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_ad = '0; in_bs = '0; in_rnw = 1'b0; in_begin = 1'b0;
        in_end = 1'b0; in_dv = 1'b0; in_be = '0; in_err = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("reset_outputs", {out_ad, out_dv, out_end, out_busy, out_err}, 36'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Preload: words 0/1 cleared, 0x10..0x13, 0x20/0x21
        wdat[0] = 32'd0; wdat[1] = 32'd0;
        run_write(BASE, 8'd1, 4'hF, 2);
        wdat[0] = 32'hDEADBEEF; wdat[1] = 32'h11111111; wdat[2] = 32'h12121212; wdat[3] = 32'h13131313;
        run_write(BASE + 32'h40, 8'd3, 4'hF, 4);
        check_eq("preload_no_err", err_seen, 1'b0);
        wdat[0] = 32'd0; wdat[1] = 32'h77777777;
        run_write(BASE + 32'h80, 8'd1, 4'hF, 2);

        run_read(BASE + 32'h40, 8'd3, 0);
        check_eq("rd_wait_no_dv", dv_log[1], 1'b0);
        check_eq("rd_beat0", {dv_log[2], ad_log[2]}, {1'b1, 32'hDEADBEEF});
        check_eq("rd_beat1", {dv_log[3], ad_log[3]}, {1'b1, 32'h11111111});
        check_eq("rd_beat2", {dv_log[4], ad_log[4]}, {1'b1, 32'h12121212});
        check_eq("rd_beat3", {dv_log[5], ad_log[5]}, {1'b1, 32'h13131313});
        check_eq("rd_no_early_end", end_log[5], 1'b0);
        check_eq("rd_end_pulse", {end_log[6], dv_log[6], ad_log[6]}, {1'b1, 1'b0, 32'd0});
        check_eq("rd_end_once", end_log[7], 1'b0);

        wdat[0] = 32'hAABBCCDD; wdat[1] = 32'h11223344;
        run_write(BASE, 8'd1, 4'b0011, 2);
        check_eq("be_wr_no_err", err_seen, 1'b0);
        run_read(BASE, 8'd1, 0);
        check_eq("be_word0", ad_log[2], 32'h0000CCDD);
        check_eq("be_word1", ad_log[3], 32'h00003344);
        check_eq("be_end", end_log[4], 1'b1);

        for (int i = 0; i < 6; i++) wdat[i] = 32'hC0DE0000 + i;
        run_write(BASE + 32'h100, 8'd5, 4'hF, 6);
        check_eq("busy_pattern", busy_mask, 16'h0048);
        run_read(BASE + 32'h100, 8'd5, 0);
        for (int i = 0; i < 6; i++) check_eq("busy_wr_word", ad_log[2 + i], 32'hC0DE0000 + i);
        check_eq("busy_rd_end", end_log[8], 1'b1);

        run_read(BASE + 32'hFFC, 8'd1, 0);
        check_eq("range_err_pulse", {err_log[1], err_log[2]}, 2'b10);
        acc = 1'b0;
        for (int c = 1; c < NLOG; c++) acc |= dv_log[c];
        check_eq("range_err_no_dv", acc, 1'b0);

        run_read(BASE + 32'hFFC, 8'd0, 0);
        check_eq("last_word_ok", {err_log[1], dv_log[2], end_log[3]}, 3'b011);

        run_read(BASE + 32'h2, 8'd0, 0);
        check_eq("misalign_err", {err_log[1], dv_log[2]}, 2'b10);

        run_read(32'h0, 8'd0, 0);
        acc = 1'b0;
        for (int c = 1; c < NLOG; c++) acc |= dv_log[c] | end_log[c] | err_log[c] | (|ad_log[c]);
        check_eq("unselected_quiet", acc, 1'b0);
        run_read(BASE + 32'h1000, 8'd0, 0);
        acc = 1'b0;
        for (int c = 1; c < NLOG; c++) acc |= dv_log[c] | end_log[c] | err_log[c];
        check_eq("above_window_quiet", acc, 1'b0);

        run_write(BASE + 32'h10, 8'd0, 4'h0, 0);
        check_eq("be_zero_err", err_seen, 1'b1);

        wdat[0] = 32'h55555555; wdat[1] = 32'h66666666;
        run_write(BASE + 32'h80, 8'd0, 4'hF, 2);
        check_eq("overrun_err", err_seen, 1'b1);
        run_read(BASE + 32'h80, 8'd1, 0);
        check_eq("overrun_word0", ad_log[2], 32'h55555555);
        check_eq("overrun_not_written", ad_log[3], 32'h77777777);

        run_read(BASE + 32'h100, 8'd7, 3);
        check_eq("abort_beat1", {dv_log[3], ad_log[3]}, {1'b1, 32'hC0DE0001});
        acc = 1'b0;
        for (int c = 4; c < NLOG; c++) acc |= dv_log[c];
        check_eq("abort_no_dv", acc, 1'b0);
        acc = 1'b0;
        for (int c = 1; c < NLOG; c++) acc |= end_log[c] | err_log[c];
        check_eq("abort_no_end_err", acc, 1'b0);
        run_read(BASE + 32'h40, 8'd3, 0);
        check_eq("post_abort_beat0", ad_log[2], 32'hDEADBEEF);
        check_eq("post_abort_beat3", ad_log[5], 32'h13131313);
        check_eq("post_abort_end", end_log[6], 1'b1);

        // Reset lands in write cycle 3, where busy is high
        in_ad = BASE + 32'h200; in_bs = 8'd3; in_rnw = 1'b0; in_be = 4'hF; in_begin = 1'b1;
        @(posedge clock); #1;
        in_begin = 1'b0; in_ad = 32'hA0A0A0A0; in_dv = 1'b1;
        @(posedge clock); #1;
        in_ad = 32'hA1A1A1A1;
        @(posedge clock); #1;
        in_ad = 32'hA2A2A2A2;
        @(negedge clock);
        check_eq("busy_before_reset", out_busy, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("reset_async", {out_ad, out_dv, out_end, out_busy, out_err}, 36'd0);
        @(posedge clock); #1;
        in_dv = 1'b0; in_ad = '0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        run_read(BASE + 32'h200, 8'd1, 0);
        check_eq("after_reset_w0", ad_log[2], 32'hA0A0A0A0);
        check_eq("after_reset_w1", ad_log[3], 32'hA1A1A1A1);
        check_eq("after_reset_end", end_log[4], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
